rx_asm: RTL
===========

// Module: rx_asm
// PURPOSE
// - UART receiver; the far end of the tx_asm transmitter. Deserialises rx_in into a DATA_WIDTH word.
// - Checks per-group even parity and the stop bit, then presents the word through a one-entry valid/ready output register.
// - Sits between the serial line and the consumer logic, in the same clk domain as the transmitter.
// - rx_in is synchronous to clk; no synchroniser is included.
// PARAMETERS
// DATA_WIDTH    16  payload bits per frame, 1..64
// CLKS_PER_BIT   1  clk cycles per serial bit; 1 matches tx_asm; >1 enables mid-bit sampling
// PORTS
// clk              input   1                    clock, rising edge
// rst_n            input   1                    asynchronous reset, active-low
// rx_in            input   1                    serial line, idle high
// parity_per_byte  input   1                    1: parity bit after every 8 data bits; 0: one parity bit after the last data bit
// data_out         output  DATA_WIDTH           received word, LSB = first data bit on the line
// valid_out        output  1                    data_out and the error flags are valid
// ready_in         input   1                    consumer accepts the word when valid_out && ready_in
// parity_err       output  1                    OR of parity_err_mask
// parity_err_mask  output  ceil(DATA_WIDTH/8)   bit g = parity mismatch in group g
// frame_err        output  1                    stop bit sampled as 0
// overrun          output  1                    1-cycle pulse: a completed frame was dropped because the output register was full
// BEHAVIOUR
// - Reset (async): state=IDLE; valid_out=0; data_out=0; parity_err_mask=0; frame_err=0; overrun=0; all counters=0.
// - Frame format: start(0), data bits LSB-first, parity bit(s), stop(1).
// - Groups:
//   - parity_per_byte=1: data bits split into 8-bit groups; the last group holds the remaining DATA_WIDTH%8 bits if nonzero.
//   - parity_per_byte=0: one group equal to the whole word.
// - Parity bit: one parity bit follows each group. Expected value = XOR of the group's data bits (even parity overall).
// - Mismatch in group g sets mask bit g. In word mode, only mask bit 0 is used.
// - parity_per_byte is sampled at start detection and held for the whole frame.
// - Sampling:
//   - CLKS_PER_BIT=1: every serial bit is sampled in its single cycle.
//   - CLKS_PER_BIT>1: the start bit is re-checked CLKS_PER_BIT/2 cycles after the falling edge. If rx_in=1 at that point, it is a false start -> IDLE. After that, one sample every CLKS_PER_BIT cycles.
// - FSM:
//   - IDLE -> START on rx_in==0.
//   - START -> DATA; counters bit_cnt, grp_bit_cnt and grp_idx are cleared here.
//   - DATA: shift in the sample at bit position bit_cnt.
//     - -> PARITY when the group is complete (grp_bit_cnt==7 in byte mode, or last data bit).
//     - else stay in DATA.
//   - PARITY: compare; then
//     - -> STOP if all DATA_WIDTH bits have been received,
//     - else -> DATA with grp_bit_cnt=0 and grp_idx+1.
//   - STOP: sample the stop bit.
//     - 1 -> IDLE.
//     - 0 -> set frame_err for this word, then WAIT_HIGH.
//   - WAIT_HIGH: stays until rx_in==1, then -> IDLE. Holding line low (break) never starts a frame.
// - Unused encodings -> IDLE.
// - Latency: valid_out rises on the cycle after the stop-bit sample. Frame errors still deliver the word, with frame_err=1.
// - Handshake:
//   - data_out, valid_out and all error flags hold stable until valid_out && ready_in.
//   - valid_out drops on the cycle after acceptance, unless a new word loads in that same cycle.
// - Simultaneous events:
//   - Word completes in the same cycle as acceptance of the held word -> load the new word, no overrun.
//   - Word completes while the register is full and not accepted -> drop the new word, keep the old one, pulse overrun.
// - Reception continues regardless of ready_in; the receiver never stalls the line.
// - Async reset mid-frame: the partial word is discarded; after release the block returns to IDLE and needs a fresh falling edge.
// TESTING (DATA_WIDTH=16, CLKS_PER_BIT=1 unless noted)
// - Byte mode, 0xA5C3, correct parity
//   - line: 0,11000011,0,10100101,0,1
//   - -> data_out=16'hA5C3, mask=2'b00, frame_err=0; valid_out 1 cycle after stop
// - Same frame, byte-1 parity bit inverted -> mask=2'b10, parity_err=1, data_out=16'hA5C3.
// - Word mode, 0x0001, parity=1, stop=0
//   - -> data_out=16'h0001, frame_err=1
//   - then rx_in held 0 for 20 cycles -> no new valid_out until rx_in returns 1.
// - ready_in=0, two back-to-back frames 0x1111 then 0x2222
//   - -> overrun pulses once; data_out stays 16'h1111.
//   - With ready_in=1 in the completion cycle of the second frame: 0x2222 loads, no overrun.
// - CLKS_PER_BIT=4: 1-cycle low glitch on rx_in -> false start, no valid_out; a full 0x00FF byte-mode frame -> data_out=16'h00FF.
// - Assert rst_n low in the middle of the DATA state -> valid_out=0, state IDLE; the next clean frame 0xBEEF is received correctly.

Source files
------------

// File: rtl/rx_asm.sv
// rx_asm -- UART receiver, far end of tx_asm.
//
// Deserialises rx_in (start bit, data LSB-first, parity bit(s), stop bit) into
// a DATA_WIDTH word. It checks even parity per 8-bit group or over the whole
// word, and checks the stop bit. The word goes to a one-entry valid/ready
// output register. Reception never stalls: a word that completes while the
// register is full and not being accepted is dropped, and overrun pulses.
//
// Ports
//   clk              rising-edge clock
//   rst_n            asynchronous reset, active-low
//   rx_in            serial line (idle high), already synchronous to clk
//   parity_per_byte  1: parity bit after every 8 data bits; 0: one parity bit for the word
//   ready_in         consumer accepts the held word when valid_out && ready_in
//   data_out         received word, bit 0 = first data bit on the line
//   valid_out        data_out and the error flags are valid
//   parity_err       OR of parity_err_mask
//   parity_err_mask  bit g set = parity mismatch in group g
//   frame_err        stop bit was sampled low
//   overrun          one-cycle pulse: a completed word was dropped
module rx_asm #(
  parameter int DATA_WIDTH   = 16,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            rx_in,
  input  logic                            parity_per_byte,
  input  logic                            ready_in,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic                            valid_out,
  output logic                            parity_err,
  output logic [(DATA_WIDTH+7)/8-1:0]     parity_err_mask,
  output logic                            frame_err,
  output logic                            overrun
);

  localparam int NUM_GRP = (DATA_WIDTH + 7) / 8;
  localparam int BIT_CW  = $clog2(DATA_WIDTH + 1);
  localparam int GRP_IW  = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
  localparam int TICK_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int HALF    = CLKS_PER_BIT / 2;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_PARITY    = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_HIGH = 3'd5;

  logic [2:0]            state;
  logic [TICK_W-1:0]     tick_cnt;
  logic [BIT_CW-1:0]     bit_cnt;
  logic [2:0]            grp_bit_cnt;
  logic [GRP_IW-1:0]     grp_idx;
  logic                  byte_mode;
  logic                  par_acc;
  logic [DATA_WIDTH-1:0] shreg;
  logic [NUM_GRP-1:0]    mask_acc;

  logic tick;
  logic data_last;
  logic grp_last;
  logic word_done;
  logic load_ok;

  // Bits arrive LSB-first: each new sample enters at the top and the word
  // moves down, so after DATA_WIDTH samples the first bit sits in bit 0.
  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] sr,
                                                     input logic                  b);
    logic [DATA_WIDTH-1:0] r;
    r = sr >> 1;
    r[DATA_WIDTH-1] = b;
    return r;
  endfunction

  always_comb begin
    tick      = (tick_cnt == TICK_W'(CLKS_PER_BIT - 1));
    data_last = (bit_cnt == BIT_CW'(DATA_WIDTH - 1));
    grp_last  = data_last || (byte_mode && (grp_bit_cnt == 3'd7));
    word_done = (state == S_STOP) && tick;
    load_ok   = !valid_out || ready_in;
  end

  assign parity_err = |parity_err_mask;

  // Receive state machine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      grp_bit_cnt <= '0;
      grp_idx     <= '0;
      byte_mode   <= 1'b0;
      par_acc     <= 1'b0;
      shreg       <= '0;
      mask_acc    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          tick_cnt <= '0;
          if (!rx_in) begin
            byte_mode <= parity_per_byte;
            // With one clock per bit, the edge that sees the start bit is
            // already its only sample. The next cycle carries data bit 0, so
            // the start re-check is skipped and DATA is entered directly.
            if (CLKS_PER_BIT == 1) begin
              bit_cnt     <= '0;
              grp_bit_cnt <= '0;
              grp_idx     <= '0;
              par_acc     <= 1'b0;
              mask_acc    <= '0;
              state       <= S_DATA;
            end else begin
              state <= S_START;
            end
          end
        end
        S_START: begin
          // Re-check the start bit mid-bit. tick_cnt then restarts, so that
          // every later sample also falls mid-bit.
          if (tick_cnt == TICK_W'(HALF - 1)) begin
            tick_cnt <= '0;
            if (rx_in) begin
              state <= S_IDLE;
            end else begin
              bit_cnt     <= '0;
              grp_bit_cnt <= '0;
              grp_idx     <= '0;
              par_acc     <= 1'b0;
              mask_acc    <= '0;
              state       <= S_DATA;
            end
          end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end
        S_DATA: begin
          tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
          if (tick) begin
            shreg       <= shift_in(shreg, rx_in);
            par_acc     <= par_acc ^ rx_in;
            bit_cnt     <= bit_cnt + BIT_CW'(1);
            grp_bit_cnt <= grp_bit_cnt + 3'd1;
            if (grp_last) state <= S_PARITY;
          end
        end
        S_PARITY: begin
          tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
          if (tick) begin
            if (rx_in != par_acc) mask_acc <= mask_acc | (NUM_GRP'(1) << grp_idx);
            par_acc <= 1'b0;
            if (bit_cnt == BIT_CW'(DATA_WIDTH)) begin
              state <= S_STOP;
            end else begin
              grp_bit_cnt <= '0;
              grp_idx     <= grp_idx + GRP_IW'(1);
              state       <= S_DATA;
            end
          end
        end
        S_STOP: begin
          tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
          if (tick) state <= rx_in ? S_IDLE : S_WAIT_HIGH;
        end
        S_WAIT_HIGH: begin
          // A held-low line (break) must not look like a new start bit.
          tick_cnt <= '0;
          if (rx_in) state <= S_IDLE;
        end
        default: begin
          state    <= S_IDLE;
          tick_cnt <= '0;
        end
      endcase
    end
  end

  // Output register: word and flags stay stable until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out        <= '0;
      valid_out       <= 1'b0;
      parity_err_mask <= '0;
      frame_err       <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (word_done) begin
        if (load_ok) begin
          data_out        <= shreg;
          parity_err_mask <= mask_acc;
          frame_err       <= !rx_in;
          valid_out       <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid_out && ready_in) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule
